ysyx_23060191_mem_arbiter: RTL

- Two-master, one-slave arbiter sharing the single data memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Uses valid/ready handshakes on every channel, with exactly one transaction outstanding at a time.
- Sits between the IFU/LSU and the memory adapter that wraps the pmem DPI-C read/write calls.
- Replaces direct combinational memory access with a sequenced request/response protocol.

---
 rtl/ysyx_23060191_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Purpose: shares one memory request/response port between the IFU (read-only) and the LSU (read/write), one transaction at a time.
// Latency: grant in cycle N, mem_req_valid in N+1, response in N+2 with zero-wait memory, next grant in N+3.
// Backpressure: request payload is held until mem_req_ready; owner rsp_ready drives mem_rsp_ready. Macro YSYX_23060191_ARB_RR_EN selects round-robin.
module ysyx_23060191_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4    // one mask bit per data byte (DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_req_wen,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rsp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Latched request payload presented to memory.
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } req_t;

    state_t state;
    logic   gnt_lsu;     // owner of the current transaction: 1 = LSU, 0 = IFU
    logic   req_vld_q;   // registered mem_req_valid
    req_t   req_q;

    logic   pick_lsu;
    logic   grant;
    logic   in_rsp;
    req_t   ifu_req;
    req_t   lsu_req;
    req_t   win_req;

`ifdef YSYX_23060191_ARB_RR_EN
    logic   last_gnt;    // 1 = LSU won the most recent grant

    // Contested grant goes to whichever master did not win last time.
    always_comb begin
        pick_lsu = lsu_req_valid && (!ifu_req_valid || !last_gnt);
    end

    // Remember the winner of every grant; LSU after reset so IFU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (grant) begin
            last_gnt <= pick_lsu;
        end
    end
`else
    // Fixed priority: the LSU always wins a tie.
    always_comb begin
        pick_lsu = lsu_req_valid;
    end
`endif

    // A grant is only possible from IDLE, and never while reset is held.
    always_comb begin
        grant = (state == IDLE) && !rst && (ifu_req_valid || lsu_req_valid);
    end

    // Build both candidate payloads; the IFU never writes, so its write fields are zero.
    always_comb begin
        ifu_req       = '0;
        ifu_req.addr  = ifu_req_addr;
        lsu_req       = '0;
        lsu_req.wen   = lsu_req_wen;
        lsu_req.addr  = lsu_req_addr;
        lsu_req.wdata = lsu_req_wdata;
        lsu_req.wmask = lsu_req_wmask;
        win_req       = pick_lsu ? lsu_req : ifu_req;
    end

    // Transaction sequencer: latch on grant, hold until memory accepts, wait for the response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_lsu   <= 1'b0;
            req_vld_q <= 1'b0;
            req_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        req_q     <= win_req;
                        gnt_lsu   <= pick_lsu;
                        req_vld_q <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        req_vld_q <= 1'b0;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rsp_valid && mem_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    req_vld_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Request side: readies only in IDLE, payload straight from the latch.
    always_comb begin
        lsu_req_ready = grant && pick_lsu;
        ifu_req_ready = grant && !pick_lsu;
        mem_req_valid = req_vld_q;
        mem_req_wen   = req_q.wen;
        mem_req_addr  = req_q.addr;
        mem_req_wdata = req_q.wdata;
        mem_req_wmask = req_q.wmask;
    end

    // Response side: route memory response to the owner only while in RSP; stray responses elsewhere are not accepted.
    always_comb begin
        in_rsp        = (state == RSP) && !rst;
        ifu_rsp_valid = in_rsp && !gnt_lsu && mem_rsp_valid;
        lsu_rsp_valid = in_rsp &&  gnt_lsu && mem_rsp_valid;
        mem_rsp_ready = in_rsp && (gnt_lsu ? lsu_rsp_ready : ifu_rsp_ready);
        ifu_rsp_rdata = mem_rsp_rdata;
        lsu_rsp_rdata = mem_rsp_rdata;
    end

    // A stalled memory request must not change under the slave's feet.
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(req_q)));

endmodule
